// File: rtl/ws2812_led_arbiter.sv
// Priority scheduler sharing one WS2812 status pixel between NUM_REQ requesters.
// Optional WS2812_ARB_DIM_EN adds a `dim` port that right-shifts each colour channel.

module ws2812_arb_slot #(
  parameter int HOLD_MS = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        set,
  input  logic        clr,
  input  logic        sticky,
  input  logic        blink,
  input  logic [23:0] color_in,
  output logic        active,
  output logic        blink_en,
  output logic [23:0] slot_color
);
  typedef enum logic [1:0] {S_IDLE, S_TIMED, S_STICKY} state_t;

  state_t      state;
  logic [15:0] hold;

  // set outranks clr and expiry, so a re-set always restarts the timer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      hold       <= '0;
      slot_color <= '0;
      blink_en   <= 1'b0;
    end else if (set) begin
      slot_color <= color_in;
      blink_en   <= blink;
      hold       <= 16'(HOLD_MS);
      state      <= sticky ? S_STICKY : S_TIMED;
    end else if (clr) begin
      state <= S_IDLE;
    end else if (state == S_TIMED && tick) begin
      hold <= hold - 16'd1;
      if (hold <= 16'd1) state <= S_IDLE;
    end
  end

  assign active = (state != S_IDLE);
endmodule

module ws2812_led_arbiter #(
  parameter int          NUM_REQ    = 4,
  parameter int          CLK_FRE    = 32_000_000,
  parameter int          HOLD_MS    = 200,
  parameter int          BLINK_MS   = 250,
  parameter logic [23:0] IDLE_COLOR = 24'h000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   set,
  input  logic [NUM_REQ-1:0]   clr,
  input  logic [NUM_REQ-1:0]   sticky,
  input  logic [NUM_REQ-1:0]   blink,
  input  logic [24*NUM_REQ-1:0] color_in,
`ifdef WS2812_ARB_DIM_EN
  input  logic [1:0]           dim,
`endif
  output logic [23:0]          color,
  output logic [NUM_REQ-1:0]   owner,
  output logic [NUM_REQ-1:0]   active,
  output logic                 changed
);
  localparam int PRE = CLK_FRE / 1000;
  localparam int PW  = (PRE > 1) ? $clog2(PRE) : 1;

  logic [PW-1:0] pre;
  logic          tick;

  assign tick = (pre == PW'(PRE - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || tick) pre <= '0;
    else                  pre <= pre + 1'b1;
  end

  // Shared blink phase; a blinking set restarts it so the colour shows first
  logic [15:0] bcnt;
  logic        phase;
  logic        blink_clr;

  assign blink_clr = |(set & blink);

  always_ff @(posedge clk) begin
    if (!reset_n || blink_clr) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      if (bcnt == 16'(BLINK_MS - 1)) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 16'd1;
      end
    end
  end

  logic [NUM_REQ-1:0]       blk;
  logic [NUM_REQ-1:0][23:0] slot_col;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    ws2812_arb_slot #(.HOLD_MS(HOLD_MS)) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .set        (set[i]),
      .clr        (clr[i]),
      .sticky     (sticky[i]),
      .blink      (blink[i]),
      .color_in   (color_in[24*i +: 24]),
      .active     (active[i]),
      .blink_en   (blk[i]),
      .slot_color (slot_col[i])
    );
  end

  logic [23:0]        sel_col;
  logic [23:0]        dimmed;
  logic [NUM_REQ-1:0] sel_own;

  // Walk from the top so the lowest active index is the last to write
  always_comb begin
    sel_col = IDLE_COLOR;
    sel_own = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (active[i]) begin
        sel_col    = (blk[i] && phase) ? 24'h000000 : slot_col[i];
        sel_own    = '0;
        sel_own[i] = 1'b1;
      end
    end
  end

`ifdef WS2812_ARB_DIM_EN
  assign dimmed = {sel_col[23:16] >> dim, sel_col[15:8] >> dim, sel_col[7:0] >> dim};
`else
  assign dimmed = sel_col;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      color   <= IDLE_COLOR;
      owner   <= '0;
      changed <= 1'b0;
    end else begin
      color   <= dimmed;
      owner   <= sel_own;
      changed <= (dimmed != color);
    end
  end
endmodule

// File: tb/tb_ws2812_led_arbiter.sv
// Directed self-checking bench for ws2812_led_arbiter (1 kHz tick from a 1 MHz clock).
module tb_ws2812_led_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  set = '0, clr = '0, sticky = '0, blink = '0;
  logic [24*N-1:0] color_in = '0;
`ifdef WS2812_ARB_DIM_EN
  logic [1:0]    dim = 2'd0;
`endif
  logic [23:0]   color;
  logic [N-1:0]  owner, active;
  logic          changed;

  int checks = 0, failures = 0;
  int n, nch, d, m;

  ws2812_led_arbiter #(
    .NUM_REQ(N), .CLK_FRE(1_000_000), .HOLD_MS(3), .BLINK_MS(2), .IDLE_COLOR(24'h000000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .set(set), .clr(clr), .sticky(sticky), .blink(blink),
    .color_in(color_in),
`ifdef WS2812_ARB_DIM_EN
    .dim(dim),
`endif
    .color(color), .owner(owner), .active(active), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic put(input int i, input logic [23:0] c, input logic st, input logic bl);
    set[i] = 1'b1; sticky[i] = st; blink[i] = bl; color_in[24*i +: 24] = c;
    cyc();
    set[i] = 1'b0;
  endtask

  task automatic drop(input int i);
    clr[i] = 1'b1;
    cyc();
    clr[i] = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_color", 32'(color), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_changed", 32'(changed), 32'h0);
    reset_n = 1'b1;
    cyc(3);

    // 1: timed request and expiry
    put(2, 24'h00FF00, 1'b0, 1'b0);
    chk("t1_active", 32'(active), 32'h4);
    cyc();
    chk("t1_color", 32'(color), 32'h00FF00);
    chk("t1_owner", 32'(owner), 32'h4);
    chk("t1_changed", 32'(changed), 32'h1);
    cyc();
    chk("t1_changed_once", 32'(changed), 32'h0);
    n = 0; nch = 0;
    while (color !== 24'h0 && n < 5000) begin
      cyc(); n++;
      if (changed) nch++;
    end
    chk("t1_expiry_window", 32'(n >= 1990 && n <= 3010), 32'h1);
    chk("t1_expiry_changed", 32'(nch), 32'h1);
    chk("t1_expiry_owner", 32'(owner), 32'h0);

    // 2: priority, clear, identical re-set
    put(2, 24'h00FF00, 1'b1, 1'b0);
    cyc();
    chk("t2_low_color", 32'(color), 32'h00FF00);
    put(0, 24'hFF0000, 1'b1, 1'b0);
    cyc();
    chk("t2_hi_color", 32'(color), 32'hFF0000);
    chk("t2_hi_owner", 32'(owner), 32'h1);
    drop(0);
    cyc();
    chk("t2_back_color", 32'(color), 32'h00FF00);
    chk("t2_back_owner", 32'(owner), 32'h4);
    put(2, 24'h00FF00, 1'b1, 1'b0);
    n = 0;
    repeat (3) begin cyc(); if (changed) n++; end
    chk("t2_same_no_changed", 32'(n), 32'h0);
    drop(2);
    cyc();
    chk("t2_idle_color", 32'(color), 32'h0);
    chk("t2_idle_active", 32'(active), 32'h0);

    // 3: blink, 2 ms half-period, colour first
    put(1, 24'h0000FF, 1'b1, 1'b1);
    cyc();
    chk("t3_first_on", 32'(color), 32'h0000FF);
    n = 0;
    while (color !== 24'h0 && n < 3000) begin cyc(); n++; end
    chk("t3_first_half", 32'(n >= 990 && n <= 2010), 32'h1);
    n = 0;
    while (color !== 24'h0000FF && n < 3000) begin cyc(); n++; end
    chk("t3_off_period", 32'(n), 32'd2000);
    n = 0;
    while (color !== 24'h0 && n < 3000) begin cyc(); n++; end
    chk("t3_on_period", 32'(n), 32'd2000);
    drop(1);
    chk("t3_clr_active", 32'(active), 32'h0);
    cyc();
    chk("t3_clr_color", 32'(color), 32'h0);

    // 4: set+clr together, re-set one cycle before expiry
    set[3] = 1'b1; clr[3] = 1'b1; sticky[3] = 1'b0; blink[3] = 1'b0;
    color_in[24*3 +: 24] = 24'h101010;
    cyc();
    set[3] = 1'b0; clr[3] = 1'b0;
    chk("t4_set_wins", 32'(active[3]), 32'h1);
    n = 1;
    while (active[3] && n < 5000) begin cyc(); n++; end
    d = n - 1;
    chk("t4_hold_len", 32'(d >= 2000 && d <= 3000), 32'h1);
    m = 1000 - (d % 1000);
    if (m > 1) cyc(m - 1);
    put(3, 24'h101010, 1'b0, 1'b0);
    cyc(d - 2);
    put(3, 24'h101010, 1'b0, 1'b0);
    cyc();
    chk("t4_reset_extends", 32'(active[3]), 32'h1);
    cyc(1500);
    chk("t4_still_active", 32'(active[3]), 32'h1);
    n = 0;
    while (active[3] && n < 2500) begin cyc(); n++; end
    chk("t4_expires_again", 32'(active[3]), 32'h0);

    // 5: reset mid-operation
    put(0, 24'hFF0000, 1'b1, 1'b1);
    put(2, 24'h00FF00, 1'b1, 1'b1);
    cyc(2);
    chk("t5_pre_owner", 32'(owner), 32'h1);
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    chk("t5_color", 32'(color), 32'h0);
    chk("t5_owner", 32'(owner), 32'h0);
    chk("t5_active", 32'(active), 32'h0);
    chk("t5_changed", 32'(changed), 32'h0);
    n = 0;
    repeat (2500) begin
      cyc();
      if (active != '0 || changed || color != 24'h0) n++;
    end
    chk("t5_quiet", 32'(n), 32'h0);

`ifdef WS2812_ARB_DIM_EN
    // 6: brightness shift
    dim = 2'd2;
    put(1, 24'hFF8040, 1'b1, 1'b0);
    cyc();
    chk("t6_dim2", 32'(color), 32'h3F2010);
    dim = 2'd0;
    cyc();
    chk("t6_dim0", 32'(color), 32'hFF8040);
    chk("t6_dim_changed", 32'(changed), 32'h1);
    cyc();
    chk("t6_changed_once", 32'(changed), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ws2812_led_arbiter.md
Name: ws2812_led_arbiter

Overview:
Status-LED scheduler that shares the single on-board WS2812 pixel between several requesters, such as floppy activity, SD-card access, error and OSD focus. Each requester posts a GRB colour with its own hold, sticky and blink attributes. The block picks the highest-priority active request and drives the registered 24-bit colour into the existing ws2812 driver's `color` input. It sits in the board top level between the system status signals and that driver.

Parameters:
- NUM_REQ, 4: number of requester slots (2..8); slot 0 has the highest priority.
- CLK_FRE, 32_000_000: clk frequency in Hz; the ms-tick prescaler is CLK_FRE/1000.
- HOLD_MS, 200: lifetime of a non-sticky request in ms (1..65535).
- BLINK_MS, 250: blink half-period in ms (1..65535).
- IDLE_COLOR, 24'h000000: colour output when no slot is active, in GRB order.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- set  in  NUM_REQ  per-slot 1-cycle pulse; latches colour and attributes and activates the slot
- clr  in  NUM_REQ  per-slot 1-cycle pulse; deactivates the slot
- sticky  in  NUM_REQ  sampled with set; 1 = slot has no hold timeout
- blink  in  NUM_REQ  sampled with set; 1 = slot blinks
- color_in  in  24*NUM_REQ  slot i colour on bits [24*i+23:24*i], GRB order
- dim  in  2  global brightness shift; present only with the macro
- color  out  24  colour for the ws2812 driver
- owner  out  NUM_REQ  one-hot winning slot; all-zero when idle
- active  out  NUM_REQ  per-slot active flags
- changed  out  1  1-cycle pulse on the cycle `color` takes a new value

Behaviour:
- Reset (reset_n=0 sampled at a clk edge):
  - all slots idle; color=IDLE_COLOR; owner=0; active=0; changed=0.
  - ms prescaler, per-slot hold counters, blink counter and blink phase all cleared.
  - Reset mid-operation aborts every request immediately; nothing is restored after reset.
- ms tick: prescaler counts 0..CLK_FRE/1000-1 and asserts an internal tick for one cycle at wrap.
- Per-slot FSM, states IDLE, TIMED, STICKY:
  - set[i] in any state: latch color_in slice, sticky[i] and blink[i]; next state is STICKY if sticky[i], else TIMED; hold counter loaded with HOLD_MS.
  - TIMED: decrement hold counter on each tick; at 0 go to IDLE.
  - clr[i] in TIMED or STICKY: go to IDLE.
  - set[i] and clr[i] in the same cycle: set wins.
  - set[i] on the same cycle as expiry: set wins and the timer restarts.
  - active[i]=1 in TIMED and STICKY, valid from the cycle after set.
- Arbitration: the lowest-index active slot wins. owner is registered alongside color.
- Blink:
  - One shared phase bit toggles every BLINK_MS ticks.
  - Any set with blink=1 clears the blink counter and phase, so the colour is shown first.
  - Winning slot with blink=1 and phase=1 outputs 24'h000000; otherwise it outputs its latched colour.
- Output pipeline: set at cycle N → active at N+1 → color/owner at N+2.
  - changed=1 at N+2 only if color differs from its previous value.
  - A re-set with an identical colour produces no changed pulse.
- No active slot: color=IDLE_COLOR, owner=0.
- Widths: hold and blink counters are 16 bits; the prescaler is wide enough for CLK_FRE/1000-1.

Optional Feature:
- Macro WS2812_ARB_DIM_EN.
- Defined: `dim` port exists; each 8-bit channel of the selected colour is logically right-shifted by dim (0..3) before the output register. IDLE_COLOR is shifted too. A dim change alone that alters color pulses changed.
- Undefined: no `dim` port; colours pass unscaled.

Test Plan:
1. CLK_FRE=1_000_000, HOLD_MS=3. set[2] with color 24'h00FF00, sticky=0, blink=0 → color=24'h00FF00 and owner=4'b0100 two cycles later, changed pulses once; color returns to IDLE_COLOR after 3 ms ±1 tick, with a second changed pulse.
2. Slot 2 sticky 24'h00FF00, then set[0] with 24'hFF0000 → color=24'hFF0000, owner=4'b0001; clr[0] → color=24'h00FF00, owner=4'b0100.
3. BLINK_MS=2, set[1] with blink=1, color 24'h0000FF sticky → color alternates 24'h0000FF / 24'h000000 every 2 ms, first half shows 24'h0000FF; clr[1] → IDLE_COLOR.
4. set[3] and clr[3] in the same cycle → active[3]=1. Re-set slot 3 one cycle before hold expiry → slot stays active for a further HOLD_MS.
5. Assert reset_n=0 for 1 cycle while slots 0 and 2 are active and blinking → next cycle all outputs at reset values; no activity until the next set.
6. With WS2812_ARB_DIM_EN, dim=2, slot color 24'hFF8040 → color=24'h3F2010. Changing dim to 0 → 24'hFF8040 with one changed pulse.
